// File: rtl/uart_bus_master_if.sv
// uart_bus_master_if: UART byte stream, mem_* bus and status signals
// master = bridge side, slave = UART/responder/environment side
interface uart_bus_master_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        dropped;

    modport master (
        input  rx_valid, rx_data, tx_ready, mem_ready, mem_rdata,
        output tx_valid, tx_data, mem_valid, mem_addr, mem_wdata,
        output mem_wstrb, busy, dropped
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, mem_ready, mem_rdata,
        input  tx_valid, tx_data, mem_valid, mem_addr, mem_wdata,
        input  mem_wstrb, busy, dropped
    );
endinterface

// File: rtl/uart_bus_master.sv
// uart_bus_master: UART-framed debug bridge issuing single-word mem_* cycles.
// Ports: clk, resetn (async low), bus (uart_bus_master_if.master). Option: UBM_TIMEOUT_EN.
module uart_bus_master #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic resetn,
    uart_bus_master_if.master bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_BUS  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] ACK  = 8'h06;
    localparam logic [7:0] NAK  = 8'h15;

    logic [2:0]  r_state;
    logic [1:0]  r_cnt;
    logic        r_is_wr;
    logic        r_rd_resp;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_rdata;
    logic        r_mem_valid;
    logic        r_tx_valid;
    logic [7:0]  r_tx_data;
    logic        r_dropped;
    logic        w_tmo;
    logic        w_last;

    assign w_last = (r_cnt == 2'd3);

`ifdef UBM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo;

    // Counts BUS cycles; zero on every entry to BUS.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tmo <= '0;
        end else if (r_state != S_BUS) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign w_tmo = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= 2'd0;
            r_is_wr     <= 1'b0;
            r_rd_resp   <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_wstrb     <= 4'h0;
            r_rdata     <= 32'd0;
            r_mem_valid <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= 8'd0;
            r_dropped   <= 1'b0;
        end else begin
            if (bus.rx_valid && (r_state == S_BUS || r_state == S_RESP)) begin
                r_dropped <= 1'b1;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (bus.rx_valid) begin
                        r_cnt <= 2'd0;
                        if (bus.rx_data == OP_W || bus.rx_data == OP_R) begin
                            r_is_wr <= (bus.rx_data == OP_W);
                            r_state <= S_ADDR;
                        end else begin
                            r_rd_resp  <= 1'b0;
                            r_tx_data  <= NAK;
                            r_tx_valid <= 1'b1;
                            r_state    <= S_RESP;
                        end
                    end
                end
                S_ADDR: begin
                    if (bus.rx_valid) begin
                        // LSB first: each byte enters at the top
                        r_addr <= {bus.rx_data, r_addr[31:8]};
                        r_cnt  <= r_cnt + 2'd1;
                        if (w_last) begin
                            r_cnt <= 2'd0;
                            if (r_is_wr) begin
                                r_state <= S_DATA;
                            end else begin
                                r_wstrb     <= 4'h0;
                                r_mem_valid <= 1'b1;
                                r_state     <= S_BUS;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (bus.rx_valid) begin
                        r_wdata <= {bus.rx_data, r_wdata[31:8]};
                        r_cnt   <= r_cnt + 2'd1;
                        if (w_last) begin
                            r_cnt       <= 2'd0;
                            r_wstrb     <= 4'hf;
                            r_mem_valid <= 1'b1;
                            r_state     <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    // mem_ready wins over an expiring timeout
                    if (bus.mem_ready) begin
                        r_mem_valid <= 1'b0;
                        r_rdata     <= bus.mem_rdata;
                        r_cnt       <= 2'd0;
                        r_rd_resp   <= !r_is_wr;
                        r_tx_data   <= r_is_wr ? ACK : bus.mem_rdata[7:0];
                        r_tx_valid  <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (w_tmo) begin
                        r_mem_valid <= 1'b0;
                        r_cnt       <= 2'd0;
                        r_rd_resp   <= 1'b0;
                        r_tx_data   <= NAK;
                        r_tx_valid  <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    // One idle cycle between bytes: 2 clocks per byte min.
                    if (r_tx_valid) begin
                        if (bus.tx_ready) begin
                            r_tx_valid <= 1'b0;
                            if (!r_rd_resp || w_last) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_cnt     <= r_cnt + 2'd1;
                                r_tx_data <= r_rdata[15:8];
                                r_rdata   <= {8'd0, r_rdata[31:8]};
                            end
                        end
                    end else begin
                        r_tx_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_valid = r_mem_valid;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_wstrb = r_wstrb;
    assign bus.tx_valid  = r_tx_valid;
    assign bus.tx_data   = r_tx_data;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.dropped   = r_dropped;
endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: table-driven frames with a bus responder and UART sink,
// plus hand-written reset and timeout sequences.
module tb_uart_bus_master;
    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    uart_bus_master_if bus_if ();

    uart_bus_master #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus_if)
    );

    typedef struct {
        logic [71:0] frame;
        int          nb;
        int          delay;
        logic [31:0] rdata;
        bit          extra;
        int          stall_at;
        int          exp_vcyc;
        int          exp_hs;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        int          exp_ntx;
        logic [31:0] exp_tx;
        bit          exp_drop;
    } vec_t;

    vec_t vecs[$];

    int total = 0;
    int bad   = 0;

    int          cur_delay = 0;
    logic [31:0] cur_rdata = 0;
    int          rcnt = 0;
    int          tx_stall = 0;

    int          hs_cnt;
    int          vcyc;
    bit          mv_prev;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [3:0]  cap_wstrb;
    bit          mem_err;
    bit          tx_err;
    bit          tx_hold;
    logic [7:0]  tx_hold_d;
    logic [7:0]  txq[$];

    // Responder: mem_ready rises in valid cycle delay+1.
    always @(negedge clk) begin
        if (bus_if.mem_valid) begin
            rcnt++;
            bus_if.mem_ready = (rcnt > cur_delay);
            bus_if.mem_rdata = cur_rdata;
        end else begin
            rcnt = 0;
            bus_if.mem_ready = 1'b0;
            bus_if.mem_rdata = 32'hxxxx_xxxx;
        end
    end

    // UART sink with optional stall.
    always @(negedge clk) begin
        if (tx_stall > 0 && bus_if.tx_valid) begin
            bus_if.tx_ready = 1'b0;
            tx_stall--;
        end else begin
            bus_if.tx_ready = 1'b1;
        end
    end

    always @(posedge clk) begin
        if (bus_if.mem_valid) begin
            vcyc++;
            if (!mv_prev) begin
                cap_addr  = bus_if.mem_addr;
                cap_wdata = bus_if.mem_wdata;
                cap_wstrb = bus_if.mem_wstrb;
            end else if (bus_if.mem_addr != cap_addr ||
                         bus_if.mem_wdata != cap_wdata ||
                         bus_if.mem_wstrb != cap_wstrb) begin
                mem_err = 1'b1;
            end
            if (bus_if.mem_ready) hs_cnt++;
        end
        mv_prev = bus_if.mem_valid;
        if (tx_hold && bus_if.tx_data != tx_hold_d) tx_err = 1'b1;
        tx_hold   = bus_if.tx_valid && !bus_if.tx_ready;
        tx_hold_d = bus_if.tx_data;
        if (bus_if.tx_valid && bus_if.tx_ready) txq.push_back(bus_if.tx_data);
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [71:0] frame, input int nb, input int delay,
        input logic [31:0] rdata, input bit extra, input int stall_at,
        input int exp_vcyc, input int exp_hs, input logic [31:0] exp_addr,
        input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
        input int exp_ntx, input logic [31:0] exp_tx, input bit exp_drop);
        vec_t v;
        v.frame = frame;       v.nb = nb;
        v.delay = delay;       v.rdata = rdata;
        v.extra = extra;       v.stall_at = stall_at;
        v.exp_vcyc = exp_vcyc; v.exp_hs = exp_hs;
        v.exp_addr = exp_addr; v.exp_wdata = exp_wdata;
        v.exp_wstrb = exp_wstrb;
        v.exp_ntx = exp_ntx;   v.exp_tx = exp_tx;
        v.exp_drop = exp_drop;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        bit          stalled = 0;
        bit          injected = 0;
        bit          done = 0;
        logic [31:0] got;
        string       p;
        p = $sformatf("v%0d", idx);
        @(negedge clk);
        cur_delay = v.delay;
        cur_rdata = v.rdata;
        hs_cnt = 0;  vcyc = 0;  mv_prev = 0;
        mem_err = 0; tx_err = 0; tx_hold = 0;
        txq.delete();
        for (int k = 0; k < v.nb; k++) begin
            @(negedge clk);
            bus_if.rx_valid = 1'b1;
            bus_if.rx_data  = v.frame[8*k +: 8];
        end
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
        chk({p, "_valid_rise"}, 32'(bus_if.mem_valid), 32'(v.exp_vcyc > 0));
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            bus_if.rx_valid = 1'b0;
            if (v.stall_at >= 0 && !stalled && txq.size() == v.stall_at) begin
                tx_stall = 5;
                stalled = 1;
            end
            if (v.extra && !injected && bus_if.mem_valid) begin
                bus_if.rx_valid = 1'b1;
                bus_if.rx_data  = 8'h00;
                injected = 1;
            end
            if (!bus_if.busy) begin
                done = 1;
                break;
            end
        end
        bus_if.rx_valid = 1'b0;
        chk({p, "_done"}, 32'(done), 32'd1);
        chk({p, "_vcyc"}, 32'(vcyc), 32'(v.exp_vcyc));
        chk({p, "_hs"}, 32'(hs_cnt), 32'(v.exp_hs));
        if (v.exp_vcyc > 0) begin
            chk({p, "_addr"}, cap_addr, v.exp_addr);
            chk({p, "_wstrb"}, 32'(cap_wstrb), 32'(v.exp_wstrb));
            if (v.exp_wstrb == 4'hf) chk({p, "_wdata"}, cap_wdata, v.exp_wdata);
            chk({p, "_mem_stable"}, 32'(mem_err), 32'd0);
        end
        got = 0;
        for (int i = 0; i < txq.size() && i < 4; i++) got |= 32'(txq[i]) << (8*i);
        chk({p, "_ntx"}, 32'(txq.size()), 32'(v.exp_ntx));
        chk({p, "_tx"}, got, v.exp_tx);
        chk({p, "_tx_stable"}, 32'(tx_err), 32'd0);
        chk({p, "_dropped"}, 32'(bus_if.dropped), 32'(v.exp_drop));
    endtask

    initial begin
        vecs.push_back(mk(72'hDE_AD_BE_EF_00_00_10_00_57, 9, 2, 32'h0, 0, -1,
                          3, 1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hf,
                          1, 32'h06, 0));
        vecs.push_back(mk(72'h02_00_00_00_52, 5, 1, 32'h0000_00A5, 0, 1,
                          2, 1, 32'h0200_0000, 32'h0, 4'h0,
                          4, 32'h0000_00A5, 0));
        vecs.push_back(mk(72'h41, 1, 0, 32'h0, 0, -1,
                          0, 0, 32'h0, 32'h0, 4'h0,
                          1, 32'h15, 0));
        vecs.push_back(mk(72'h12_34_56_78_11_22_33_44_57, 9, 3, 32'h0, 1, -1,
                          4, 1, 32'h1122_3344, 32'h1234_5678, 4'hf,
                          1, 32'h06, 1));
        vecs.push_back(mk(72'h00_00_00_10_52, 5, 0, 32'hCAFE_F00D, 0, -1,
                          1, 1, 32'h0000_0010, 32'h0, 4'h0,
                          4, 32'hCAFE_F00D, 1));
        vecs.push_back(mk(72'h80_00_00_04_52, 5, 1, 32'h0102_0304, 0, -1,
                          2, 1, 32'h8000_0004, 32'h0, 4'h0,
                          4, 32'h0102_0304, 0));
`ifdef UBM_TIMEOUT_EN
        vecs.push_back(mk(72'hDE_AD_BE_EF_00_00_10_00_57, 9, 1000, 32'h0, 0, -1,
                          16, 0, 32'h0000_1000, 32'hDEAD_BEEF, 4'hf,
                          1, 32'h15, 0));
        vecs.push_back(mk(72'h00_00_00_20_52, 5, 15, 32'h89AB_CDEF, 0, -1,
                          16, 1, 32'h0000_0020, 32'h0, 4'h0,
                          4, 32'h89AB_CDEF, 0));
`endif

        resetn = 1'b0;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_mem_valid", 32'(bus_if.mem_valid), 32'd0);
        chk("rst_tx_valid", 32'(bus_if.tx_valid), 32'd0);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_dropped", 32'(bus_if.dropped), 32'd0);
        chk("rst_mem_addr", bus_if.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus_if.mem_wdata, 32'd0);
        chk("rst_mem_wstrb", 32'(bus_if.mem_wstrb), 32'd0);
        chk("rst_tx_data", 32'(bus_if.tx_data), 32'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Reset while a read is stuck in BUS.
        @(negedge clk);
        cur_delay = 1000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus_if.rx_valid = 1'b1;
            bus_if.rx_data  = (k == 0) ? 8'h52 : 8'h00;
        end
        @(negedge clk);
        bus_if.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_bus_valid", 32'(bus_if.mem_valid), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("async_mem_valid", 32'(bus_if.mem_valid), 32'd0);
        chk("async_busy", 32'(bus_if.busy), 32'd0);
        chk("async_dropped", 32'(bus_if.dropped), 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 5; i < vecs.size(); i++) run_vec(vecs[i], i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
